lif_neuron_array: RTL and testbench

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

---
 rtl/lif_neuron_array.sv | 138 +++++++++++++
 tb/tb_lif_neuron_array.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one update datapath.
// A step pulse sweeps the neurons one per cycle, then publishes the spike vector.
module lif_neuron_array #(
   parameter int N_NEURONS = 4,
   parameter int W         = 8,
   parameter int RW        = 4,
   localparam int SW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   step,
   input  logic [N_NEURONS*W-1:0] in_current,
   input  logic [W-1:0]           threshold,
   input  logic                   leak_mode,
   input  logic [W-1:0]           leak_amt,
   input  logic                   reset_mode,
   input  logic [RW-1:0]          refrac_len,
   input  logic [SW-1:0]          mem_sel,
   output logic                   busy,
   output logic                   done,
   output logic [N_NEURONS-1:0]   spikes,
   output logic [W-1:0]           mem_out,
   output logic [1:0]             fsm_state
);

   // Handshake: step is honoured only in IDLE; busy covers RUN and FINISH,
   // done is high for the single FINISH cycle and spikes update as it ends.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

   state_t state, state_nx;

   logic [N_NEURONS-1:0][W-1:0]  u_q;
   logic [N_NEURONS-1:0][RW-1:0] rc_q;
   logic [N_NEURONS-1:0]         spk_sh_q;
   logic [SW-1:0]                idx_q;
   logic [N_NEURONS*W-1:0]       cur_q;
   logic [W-1:0]                 thr_q;
   logic [W-1:0]                 la_q;
   logic                         lm_q;
   logic                         rm_q;
   logic [RW-1:0]                rl_q;

   logic [W-1:0]  u_cur, i_cur, leaked, sum, u_next;
   logic [W:0]    sum_w;
   logic [RW-1:0] rc_cur, rc_next;
   logic          spk_next;
   logic          last_idx;

   assign last_idx  = (idx_q == SW'(N_NEURONS - 1));
   assign fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (step) state_nx = RUN;
         RUN:     if (last_idx) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == FINISH);
   end

   // Update of the currently indexed neuron, using only latched configuration.
   always_comb begin
      u_cur  = u_q[idx_q];
      i_cur  = cur_q[idx_q*W +: W];
      rc_cur = rc_q[idx_q];
      leaked = '0;
      if (!lm_q) begin
         if ({1'b0, la_q[3:0]} < 5'(W)) leaked = u_cur >> la_q[3:0];
      end else if (u_cur > la_q) begin
         leaked = u_cur - la_q;
      end
      sum_w = {1'b0, leaked} + {1'b0, i_cur};
      sum   = sum_w[W] ? '1 : sum_w[W-1:0];
      if (rc_cur != '0) begin
         u_next   = '0;
         rc_next  = rc_cur - RW'(1);
         spk_next = 1'b0;
      end else if (sum >= thr_q) begin
         u_next   = rm_q ? (sum - thr_q) : '0;
         rc_next  = rl_q;
         spk_next = 1'b1;
      end else begin
         u_next   = sum;
         rc_next  = rc_cur;
         spk_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         u_q      <= '0;
         rc_q     <= '0;
         spk_sh_q <= '0;
         idx_q    <= '0;
         cur_q    <= '0;
         thr_q    <= '0;
         la_q     <= '0;
         lm_q     <= 1'b0;
         rm_q     <= 1'b0;
         rl_q     <= '0;
         spikes   <= '0;
         mem_out  <= '0;
      end else begin
         mem_out <= (int'(mem_sel) < N_NEURONS) ? u_q[mem_sel] : '0;
         case (state)
            IDLE: if (step) begin
               cur_q <= in_current;
               thr_q <= threshold;
               lm_q  <= leak_mode;
               la_q  <= leak_amt;
               rm_q  <= reset_mode;
               rl_q  <= refrac_len;
               idx_q <= '0;
            end
            RUN: begin
               u_q[idx_q]      <= u_next;
               rc_q[idx_q]     <= rc_next;
               spk_sh_q[idx_q] <= spk_next;
               if (!last_idx) idx_q <= idx_q + SW'(1);
            end
            FINISH: spikes <= spk_sh_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Randomized and directed checks of lif_neuron_array against an arithmetic
// model of the neuron rules kept in plain integer arrays.
module tb_lif_neuron_array;
  localparam int N = 4;
  localparam int W = 8;
  localparam int RW = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step = 1'b0;
  logic [N*W-1:0] in_current = '0;
  logic [W-1:0] threshold = '0;
  logic leak_mode = 1'b0;
  logic [W-1:0] leak_amt = '0;
  logic reset_mode = 1'b0;
  logic [RW-1:0] refrac_len = '0;
  logic [SW-1:0] mem_sel = '0;
  logic busy, done;
  logic [N-1:0] spikes;
  logic [W-1:0] mem_out;
  logic [1:0] fsm_state;

  lif_neuron_array #(.N_NEURONS(N), .W(W), .RW(RW)) dut (
    .clk(clk), .rst(rst), .step(step), .in_current(in_current),
    .threshold(threshold), .leak_mode(leak_mode), .leak_amt(leak_amt),
    .reset_mode(reset_mode), .refrac_len(refrac_len), .mem_sel(mem_sel),
    .busy(busy), .done(done), .spikes(spikes), .mem_out(mem_out),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int mu[N];
  int mrc[N];
  logic [N-1:0] exp_spk;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mu[k] = 0;
      mrc[k] = 0;
    end
    exp_spk = '0;
  endtask

  // One timestep of the neuron rules, using the values currently driven.
  task automatic model_step();
    int sh, lk, s, cur, thr;
    thr = int'(threshold);
    for (int k = 0; k < N; k++) begin
      cur = int'(in_current[k*W +: W]);
      if (mrc[k] > 0) begin
        mu[k] = 0;
        mrc[k] = mrc[k] - 1;
        exp_spk[k] = 1'b0;
      end else begin
        if (leak_mode == 1'b0) begin
          sh = int'(leak_amt) % 16;
          lk = (sh >= W) ? 0 : mu[k] / (1 << sh);
        end else begin
          lk = (mu[k] > int'(leak_amt)) ? mu[k] - int'(leak_amt) : 0;
        end
        s = lk + cur;
        if (s > (1 << W) - 1) s = (1 << W) - 1;
        if (s >= thr) begin
          exp_spk[k] = 1'b1;
          mu[k] = reset_mode ? s - thr : 0;
          mrc[k] = int'(refrac_len);
        end else begin
          exp_spk[k] = 1'b0;
          mu[k] = s;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_step(input bit perturb);
    int cnt;
    mem_sel = '0;
    model_step();
    for (int k = 0; k < N; k++) exp_q.push_back(W'(mu[k]));
    step = 1'b1;
    tick();
    cnt = 1;
    check("busy_run", busy, 1);
    if (perturb) begin
      in_current = {$urandom, $urandom};
      threshold = W'($urandom);
      leak_mode = 1'($urandom);
      leak_amt = W'($urandom);
      reset_mode = 1'($urandom);
      refrac_len = RW'($urandom);
    end else begin
      step = 1'b0;
    end
    while (!done && cnt < 20) begin
      tick();
      cnt++;
      if (cnt == 2) step = 1'b0;
      if (cnt == 3) check("mem_mid", mem_out, mu[0]);
    end
    step = 1'b0;
    check("latency", cnt, N + 1);
    check("done", done, 1);
    tick();
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("spikes", spikes, exp_spk);
    for (int k = 0; k < N; k++) begin
      mem_sel = SW'(k);
      tick();
      check("mem", mem_out, exp_q.pop_front());
    end
  endtask

  initial begin
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_spikes", spikes, 0);
    check("rst_mem", mem_out, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;
    model_reset();

    // Integration to threshold with no leak, both reset modes.
    for (int rm = 0; rm < 2; rm++) begin
      do_reset();
      in_current = '0;
      in_current[W-1:0] = 8'd40;
      threshold = 8'd100;
      leak_mode = 1'b1;
      leak_amt = '0;
      reset_mode = 1'(rm);
      refrac_len = '0;
      for (int t = 1; t <= 3; t++) begin
        run_step(1'b0);
        check("int_spk0", spikes[0], (t == 3) ? 1 : 0);
      end
      mem_sel = '0;
      tick();
      check("int_mem0", mem_out, (rm == 1) ? 20 : 0);
    end

    // Saturation of the sum.
    do_reset();
    in_current = '0;
    in_current[W-1:0] = 8'd200;
    threshold = 8'd255;
    leak_mode = 1'b1;
    leak_amt = '0;
    reset_mode = 1'b0;
    refrac_len = '0;
    run_step(1'b0);
    in_current[W-1:0] = 8'd255;
    run_step(1'b0);
    check("sat_spk0", spikes[0], 1);
    mem_sel = '0;
    tick();
    check("sat_mem0", mem_out, 0);

    // Refractory period of two timesteps.
    do_reset();
    in_current = {N{8'd50}};
    threshold = 8'd50;
    refrac_len = RW'(2);
    for (int t = 0; t < 6; t++) begin
      run_step(1'b0);
      check("refr_spk", spikes, (t % 3 == 0) ? 4'hF : 4'h0);
    end

    // Shift leak halves the potential each timestep.
    do_reset();
    in_current = '0;
    in_current[W-1:0] = 8'd128;
    threshold = 8'd255;
    leak_mode = 1'b0;
    leak_amt = 8'd1;
    refrac_len = '0;
    run_step(1'b0);
    in_current = '0;
    for (int t = 0; t < 3; t++) begin
      run_step(1'b0);
      mem_sel = '0;
      tick();
      check("leak_mem0", mem_out, 64 >> t);
    end

    // Second step while busy is ignored; done once, busy for five cycles.
    do_reset();
    in_current = {N{8'd30}};
    model_step();
    step = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      check("hs_busy", busy, (c <= N + 1) ? 1 : 0);
      check("hs_done", done, (c == N + 1) ? 1 : 0);
      step = (c == 2);
      tick();
    end
    step = 1'b0;

    // Reset in the middle of a run aborts it.
    do_reset();
    in_current = {N{8'd255}};
    threshold = 8'd10;
    run_step(1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_spikes", spikes, 0);
    check("abort_mem", mem_out, 0);
    check("abort_state", fsm_state, 0);
    tick();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      check("abort_nodone", done, 0);
      tick();
    end
    run_step(1'b0);

    // Randomized configurations with inputs disturbed during each run.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < N; k++) in_current[k*W +: W] = W'($urandom_range(0, 120));
      threshold = W'($urandom_range(0, 255));
      leak_mode = 1'($urandom_range(0, 1));
      leak_amt = leak_mode ? W'($urandom_range(0, 80)) : W'($urandom_range(0, 15));
      reset_mode = 1'($urandom_range(0, 1));
      refrac_len = RW'($urandom_range(0, 3));
      run_step(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
